gray_codec_pipe: RTL and testbench
==================================

// Module: gray_codec_pipe
// PURPOSE
//   Parametrised, pipelined binary<->Gray converter with valid/ready handshake.
//   Each transaction carries its own mode: binary->Gray or Gray->binary.
//   Gray->binary is a prefix-XOR chain that is split across STAGES register stages,
//   so wide codes still close timing.
//   Sits between CDC pointer logic / encoders and downstream consumers; full
//   throughput of one word per cycle.
// PARAMETERS
//   WIDTH   4  code width in bits, >=2
//   STAGES  1  register stages (= latency), 1..WIDTH
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   in_valid    in   1      input word valid
//   in_ready    out  1      block accepts input this cycle
//   in_mode     in   1      0 = bin->Gray, 1 = Gray->bin
//   in_data     in   WIDTH  word to convert
//   out_valid   out  1      output word valid
//   out_ready   in   1      consumer accepts output this cycle
//   out_mode    out  1      mode of the word on out_data
//   out_data    out  WIDTH  converted word
//   out_parity  out  1      present only with GRAY_PARITY_EN
// BEHAVIOUR
//   Interface
//   - One clock; reset is asynchronous and active-high.
//   - rst asserted: all stage valids = 0, stage data/mode = 0, out_valid = 0,
//     out_data = 0, out_mode = 0, out_parity = 0. Takes effect immediately, no clock needed.
//   Handshake
//   - Transfer occurs on a clock edge where valid && ready; otherwise no transfer.
//   - in_ready = !v[0] || adv[0], where adv[k] = !v[k+1] || adv[k+1] and
//     adv[STAGES-1] = out_ready. Bubbles collapse.
//   - in_ready depends combinationally on out_ready. No combinational path from in_* to out_*.
//   - Stalled stage (v[k] && !adv[k]) holds data, mode and valid unchanged.
//   - out_valid/out_data/out_mode stay stable while out_valid && !out_ready.
//   - Stage k valid: set when the upstream word advances into it; cleared when
//     the stage advances with no word coming in.
//   Latency and data path
//   - Latency is exactly STAGES cycles, input transfer to out_valid, with no stalls.
//   - Throughput: 1 word/cycle with out_ready held high.
//   - bin->Gray: g = b ^ (b >> 1), computed fully in stage 0. Later stages pass it through.
//   - Gray->bin: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
//     - Bits are resolved MSB-first in chunks of C = ceil(WIDTH/STAGES).
//     - Stage k resolves bits [WIDTH-1-k*C -: C], clipped at bit 0.
//     - Stage k carries the unresolved Gray bits and the running b[i+1] to stage k+1.
//     - Stages that have no bits left to resolve pass data through.
//   - Each word's mode travels with it. Mixed-mode back-to-back words are legal.
//   - Per-stage data register holds WIDTH bits: resolved binary MSBs concatenated
//     with the remaining Gray LSBs.
//   Boundary conditions
//   - All-zero input maps to all-zero output in both modes.
//   - Output is correct for max code 2^WIDTH-1; no overflow exists.
//   - Input and output transfer in the same cycle with the pipe full: both occur, occupancy unchanged.
//   - rst mid-stream: in-flight words are discarded. First post-reset input
//     appears after exactly STAGES cycles.
//   - in_data is ignored while !in_valid; it does not disturb the registers.
// CONFIGURATION
//   GRAY_PARITY_EN defined
//   - Adds out_parity = XOR of all bits of the original input word.
//   - Computed in stage 0 and pipelined alongside the data.
//   - Stalls and resets like the data.
//   - For Gray->bin words it equals out_data[0]; the bench checks this.
//   GRAY_PARITY_EN undefined
//   - Port and registers are absent. All other behaviour is identical.
// STRUCTURE
//   Package gray_codec_pkg
//   - Constants MODE_B2G = 1'b0 and MODE_G2B = 1'b1.
//   - Function chunk_bits(WIDTH, STAGES) returning C.
//   - Function lo_bit(k, WIDTH, C) returning the low bit of stage k's chunk.
//   Sub-module gray_codec_stage
//   - One register stage: valid/data/mode (+parity) registers and its advance logic.
//   - Parameters WIDTH, HI, LO (bit range to resolve).
//   - Instantiated STAGES times in a generate loop. Stage 0 also performs bin->Gray.
// TESTING
//   1 WIDTH=4, STAGES=1: sweep all 16 bin->Gray, e.g. 4'b1011 -> 4'b1110 after 1 cycle.
//   2 WIDTH=4, STAGES=1: sweep all 16 Gray->bin, e.g. 4'b1000 -> 4'b1111.
//     Also check round trip g2b(b2g(x)) == x.
//   3 WIDTH=8, STAGES=3, out_ready=1: 256 back-to-back alternating-mode words.
//     Expect one output per cycle, first after 3 cycles; 8'hA5 g2b -> 8'hC6.
//   4 WIDTH=8, STAGES=3: random out_ready (50%).
//     Outputs hold stable while stalled; in-order, no loss or duplication;
//     in_ready low only when the pipe is full and stalled.
//   5 Assert rst for one cycle with 3 words in flight.
//     out_valid drops immediately and outputs read 0; no stale words emerge;
//     next word appears after STAGES cycles.
//   6 GRAY_PARITY_EN: in_data 4'b0111 b2g -> out_parity 1.
//     For every g2b word, out_parity == out_data[0].

Source files
------------

// File: rtl/gray_codec_pkg.sv
// gray_codec_pkg
//   Shared constants and elaboration helpers for the pipelined binary<->Gray
//   codec (gray_codec_pipe and its per-stage sub-module gray_codec_stage).
//   - MODE_B2G / MODE_G2B : per-word conversion mode encoding.
//   - chunk_bits          : number of Gray->binary bits resolved per stage.
//   - hi_bit / lo_bit     : bit range a given stage resolves (hi may be < 0
//                           for trailing stages that have nothing left to do).
package gray_codec_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // C = ceil(width / stages)
  function automatic int chunk_bits(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Top bit of stage k's chunk; negative once all bits are already resolved.
  function automatic int hi_bit(input int k, input int width, input int c);
    return width - 1 - k * c;
  endfunction

  // Low bit of stage k's chunk, clipped at bit 0.
  function automatic int lo_bit(input int k, input int width, input int c);
    int lo;
    lo = width - (k + 1) * c;
    return (lo < 0) ? 0 : lo;
  endfunction

endpackage

// File: rtl/gray_codec_pipe_if.sv
// gray_codec_pipe_if
//   Bundles the input and output valid/ready channels of gray_codec_pipe.
//   Signals:
//     in_valid/in_ready/in_mode/in_data     upstream channel
//     out_valid/out_ready/out_mode/out_data downstream channel
//     out_parity                            only with GRAY_PARITY_EN defined
//   Modports:
//     slave  : the codec's view (consumes in_*, produces out_*)
//     master : the environment's view (produces in_*, consumes out_*)
//   Optional feature macro: GRAY_PARITY_EN
interface gray_codec_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [WIDTH-1:0] out_data;
`ifdef GRAY_PARITY_EN
  logic             out_parity;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_parity
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_parity
  );
`else
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );
`endif

endinterface

// File: rtl/gray_codec_stage.sv
// gray_codec_stage
//   One register stage of the Gray codec pipeline.
//   - Holds valid, data, mode (and parity with GRAY_PARITY_EN) registers.
//   - Gray->binary words: resolves bits [HI:LO] with the prefix-XOR chain,
//     using the already-resolved binary bit above HI as the running value.
//     HI < 0 means nothing is left to resolve and data passes through.
//   - FIRST stage additionally performs the complete binary->Gray conversion.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     v_i            upstream word valid
//     mode_i/data_i  upstream word
//     par_i          upstream parity (GRAY_PARITY_EN only)
//     adv_i          downstream can take this stage's word
//     ready_o        this stage can take a word this cycle
//     v_o/mode_o/data_o/par_o  registered stage contents
//   Optional feature macro: GRAY_PARITY_EN
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int HI    = 3,
  parameter int LO    = 0,
  parameter int FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
`ifdef GRAY_PARITY_EN
  input  logic             par_i,
  output logic             par_o,
`endif
  input  logic             adv_i,
  output logic             ready_o,
  output logic             v_o,
  output logic             mode_o,
  output logic [WIDTH-1:0] data_o
);

  logic             v_q;
  logic             mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             run;
  int               bit_idx;

  // Bubbles collapse: an empty stage always accepts.
  assign ready_o = !v_q || adv_i;

  // Walk MSB->LSB; bits above HI are already binary, so after each bit
  // 'run' carries b[i] for the next lower bit.
  always_comb begin
    data_d  = data_i;
    run     = 1'b0;
    bit_idx = 0;
    if (FIRST != 0 && mode_i == MODE_B2G) begin
      data_d = data_i ^ (data_i >> 1);
    end else if (mode_i == MODE_G2B) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        bit_idx = WIDTH - 1 - int'(j);
        if (bit_idx <= HI && bit_idx >= LO) begin
          data_d[bit_idx] = run ^ data_i[bit_idx];
        end
        run = data_d[bit_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      mode_q <= 1'b0;
      data_q <= '0;
    end else if (ready_o) begin
      v_q <= v_i;
      if (v_i) begin
        mode_q <= mode_i;
        data_q <= data_d;
      end
    end
  end

`ifdef GRAY_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (ready_o && v_i) begin
      par_q <= par_i;
    end
  end

  assign par_o = par_q;
`endif

  assign v_o    = v_q;
  assign mode_o = mode_q;
  assign data_o = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe
//   Pipelined binary<->Gray converter with valid/ready handshake on both
//   sides. Each word carries its own mode (MODE_B2G / MODE_G2B). Latency is
//   STAGES cycles, throughput one word per cycle; the Gray->binary prefix-XOR
//   chain is split MSB-first across the stages in chunks of ceil(WIDTH/STAGES).
//   Parameters:
//     WIDTH   code width, >= 2
//     STAGES  register stages (= latency), 1..WIDTH
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous active-high reset
//     bus   gray_codec_pipe_if slave modport (in_* / out_* channels)
//   Optional feature macro: GRAY_PARITY_EN adds out_parity, the XOR of all
//   bits of the original input word, pipelined alongside the data.
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  gray_codec_pipe_if.slave  bus
);

  localparam int C = chunk_bits(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH) begin : g_param_check
    $error("gray_codec_pipe: illegal WIDTH/STAGES combination");
  end

  // Index k is the input of stage k; index STAGES is the pipeline output.
  logic [STAGES:0]  v;
  logic [STAGES:0]  m;
  logic [STAGES:0]  acc;
  logic [WIDTH-1:0] d [STAGES+1];

  assign v[0]        = bus.in_valid;
  assign m[0]        = bus.in_mode;
  assign d[0]        = bus.in_data;
  assign acc[STAGES] = bus.out_ready;
  assign bus.in_ready = acc[0];

`ifdef GRAY_PARITY_EN
  logic [STAGES:0] p;
  assign p[0] = ^bus.in_data;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    gray_codec_stage #(
      .WIDTH (WIDTH),
      .HI    (hi_bit(k, WIDTH, C)),
      .LO    (lo_bit(k, WIDTH, C)),
      .FIRST ((k == 0) ? 1 : 0)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .v_i     (v[k]),
      .mode_i  (m[k]),
      .data_i  (d[k]),
`ifdef GRAY_PARITY_EN
      .par_i   (p[k]),
      .par_o   (p[k+1]),
`endif
      .adv_i   (acc[k+1]),
      .ready_o (acc[k]),
      .v_o     (v[k+1]),
      .mode_o  (m[k+1]),
      .data_o  (d[k+1])
    );
  end

  assign bus.out_valid = v[STAGES];
  assign bus.out_mode  = m[STAGES];
  assign bus.out_data  = d[STAGES];
`ifdef GRAY_PARITY_EN
  assign bus.out_parity = p[STAGES];
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe
//   Directed bench for gray_codec_pipe: a WIDTH=4/STAGES=1 instance (dut_a)
//   and a WIDTH=8/STAGES=3 instance (dut_b) sharing clock and reset.
//   Optional feature macro: GRAY_PARITY_EN (parity checks compiled in).
module tb_gray_codec_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_codec_pipe_if #(.WIDTH(4)) ifa ();
  gray_codec_pipe_if #(.WIDTH(8)) ifb ();

  gray_codec_pipe #(.WIDTH(4), .STAGES(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  gray_codec_pipe #(.WIDTH(8), .STAGES(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // 4-bit reflected Gray code, written out by hand.
  logic [3:0] GRAY4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  // Expected {mode, result} for an 8-bit word; Gray->bin as XOR of all right shifts.
  function automatic logic [8:0] exp8(input logic mode, input logic [7:0] x);
    logic [7:0] r;
    if (mode) begin
      r = x;
      for (int s = 1; s < 8; s++) r = r ^ (x >> s);
    end else begin
      r = x ^ (x >> 1);
    end
    return {mode, r};
  endfunction

  // Back-to-back sweep of all 16 codes through dut_a in one mode.
  task automatic sweep_a(input logic mode);
    logic [3:0] xi;
    for (int unsigned i = 0; i <= 16; i++) begin
      if (i > 0) begin
        xi = 4'(i - 1);
        check("a_valid", 32'(ifa.out_valid), 32'd1);
        check("a_mode", 32'(ifa.out_mode), 32'(mode));
        check(mode ? "a_g2b" : "a_b2g", 32'(ifa.out_data), mode ? 32'(xi) : 32'(GRAY4[xi]));
`ifdef GRAY_PARITY_EN
        check("a_parity", 32'(ifa.out_parity), mode ? 32'(xi[0]) : 32'(^xi));
        if (mode) check("a_par_lsb", 32'(ifa.out_parity), 32'(ifa.out_data[0]));
`endif
      end
      check("a_in_ready", 32'(ifa.in_ready), 32'd1);
      if (i < 16) begin
        ifa.in_valid = 1'b1;
        ifa.in_mode  = mode;
        ifa.in_data  = mode ? GRAY4[i] : 4'(i);
      end else begin
        ifa.in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [8:0]  sb [$];
    logic [8:0]  held;
    logic [8:0]  got;
    logic [31:0] rnd;
    logic [7:0]  cur_d;
    logic        cur_m;
    logic        need_new;
    logic        stall_prev;
    logic        exp_rdy;
    logic        fire_in;
    logic        fire_out;
    int          occ;
    int          sent;

    ifa.in_valid = 1'b0; ifa.in_mode = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_mode = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_a_data", 32'(ifa.out_data), 32'd0);
    check("rst_a_mode", 32'(ifa.out_mode), 32'd0);
    check("rst_b_valid", 32'(ifb.out_valid), 32'd0);
    check("rst_b_data", 32'(ifb.out_data), 32'd0);
`ifdef GRAY_PARITY_EN
    check("rst_a_parity", 32'(ifa.out_parity), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Full bin->Gray and Gray->bin sweeps (Gray inputs taken from the table,
    // so the g2b pass is also the round trip)
    sweep_a(1'b0);
    sweep_a(1'b1);

    // Idle input data must not disturb the registers
    ifa.in_data = 4'h6;
    @(negedge clk);
    check("a_idle_valid", 32'(ifa.out_valid), 32'd0);
    check("a_idle_data", 32'(ifa.out_data), 32'hF);

    // dut_b: 256 back-to-back words, alternating mode, out_ready high
    for (int c = 0; c <= 258; c++) begin
      if (c < 3) begin
        check("b_latency", 32'(ifb.out_valid), 32'd0);
      end else begin
        check("b_stream_valid", 32'(ifb.out_valid), 32'd1);
        got = {ifb.out_mode, ifb.out_data};
        check("b_stream_data", 32'(got), 32'(exp8(1'(c - 3), 8'(c - 3))));
        if (c - 3 == 8'hA5) check("b_a5_g2b", 32'(ifb.out_data), 32'hC6);
      end
      if (c < 256) begin
        check("b_stream_rdy", 32'(ifb.in_ready), 32'd1);
        ifb.in_valid = 1'b1;
        ifb.in_mode  = 1'(c);
        ifb.in_data  = 8'(c);
      end else begin
        ifb.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b_stream_empty", 32'(ifb.out_valid), 32'd0);

    // dut_b: random out_ready backpressure, in order, no loss/duplication
    occ = 0; sent = 0; need_new = 1'b1; stall_prev = 1'b0; held = '0;
    cur_d = '0; cur_m = 1'b0;
    for (int cyc = 0; cyc < 400 && (sent < 100 || sb.size() > 0); cyc++) begin
      if (stall_prev) begin
        check("b_hold_valid", 32'(ifb.out_valid), 32'd1);
        check("b_hold_data", 32'({ifb.out_mode, ifb.out_data}), 32'(held));
      end
      ifb.out_ready = (sent < 100) ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (sent < 100) begin
        if (need_new) begin
          rnd = $urandom;
          cur_d = rnd[7:0];
          cur_m = rnd[8];
          need_new = 1'b0;
        end
        ifb.in_valid = 1'b1;
        ifb.in_data  = cur_d;
        ifb.in_mode  = cur_m;
      end else begin
        ifb.in_valid = 1'b0;
      end
      #1;
      exp_rdy = (occ < 3) || ifb.out_ready;
      check("b_in_ready", 32'(ifb.in_ready), 32'(exp_rdy));
      fire_in  = ifb.in_valid && exp_rdy;
      fire_out = ifb.out_valid && ifb.out_ready;
      if (fire_out) begin
        if (sb.size() == 0) begin
          check("b_extra_word", 32'd1, 32'd0);
        end else begin
          check("b_order", 32'({ifb.out_mode, ifb.out_data}), 32'(sb.pop_front()));
        end
      end
      if (fire_in) begin
        sb.push_back(exp8(cur_m, cur_d));
        sent++;
        need_new = 1'b1;
      end
      occ = occ + (fire_in ? 1 : 0) - (fire_out ? 1 : 0);
      stall_prev = ifb.out_valid && !ifb.out_ready;
      held = {ifb.out_mode, ifb.out_data};
      @(negedge clk);
    end
    check("b_drain", 32'(sb.size()), 32'd0);
    check("b_sent", 32'(sent), 32'd100);
    ifb.in_valid = 1'b0;
    ifb.out_ready = 1'b1;
    @(negedge clk);

    // Reset mid-stream with three words resident in dut_b
    ifb.out_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      ifb.in_valid = 1'b1;
      ifb.in_mode  = 1'b1;
      ifb.in_data  = 8'(8'h81 + w);
      @(negedge clk);
    end
    ifb.in_valid = 1'b0;
    check("b_full_valid", 32'(ifb.out_valid), 32'd1);
    check("b_full_rdy", 32'(ifb.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("b_arst_valid", 32'(ifb.out_valid), 32'd0);
    check("b_arst_data", 32'(ifb.out_data), 32'd0);
    check("b_arst_mode", 32'(ifb.out_mode), 32'd1 - 32'd1);
    check("b_arst_rdy", 32'(ifb.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ifb.out_ready = 1'b1;
    check("b_post_rst", 32'(ifb.out_valid), 32'd0);
    ifb.in_valid = 1'b1;
    ifb.in_mode  = 1'b0;
    ifb.in_data  = 8'h3C;
    @(negedge clk);
    ifb.in_valid = 1'b0;
    check("b_no_stale1", 32'(ifb.out_valid), 32'd0);
    @(negedge clk);
    check("b_no_stale2", 32'(ifb.out_valid), 32'd0);
    @(negedge clk);
    check("b_rst_first_v", 32'(ifb.out_valid), 32'd1);
    check("b_rst_first_d", 32'(ifb.out_data), 32'h22);
    @(negedge clk);
    check("b_rst_single", 32'(ifb.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
